// File: rtl/nf_uart_loader_pkg.sv
// rtl/nf_uart_loader_pkg.sv - shared state encoding and protocol byte constants for the UART loader
package nf_uart_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4,
        S_CAPT  = 3'd5,
        S_RESP  = 3'd6
    } state_t;

    localparam logic [7:0] CMD_W   = 8'h57;
    localparam logic [7:0] CMD_R   = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;

endpackage

// File: rtl/nf_uart_loader_tmr.sv
// rtl/nf_uart_loader_tmr.sv - inter-byte idle timer for the UART loader
// Ports: clk, resetn (async, active-high), clear (zero the count),
//        enable (count while high), expire (count at TIMEOUT_CYC-1 while enabled).
module nf_uart_loader_tmr #(
    parameter int TIMEOUT_CYC = 8680
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    // Saturates at LAST so a stalled enable can never wrap back to zero.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && cnt != LAST) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/nf_uart_loader.sv
// rtl/nf_uart_loader.sv - UART byte-stream to 32-bit bus read/write bridge
// Ports: clk, resetn (async, active-high); rx_data/rx_valid from the UART receiver;
//        tx_data/tx_valid/tx_ready to the UART transmitter; addr/wd/we/re/rd bus side;
//        busy (not idle), err (one-cycle pulse on bad command, timeout, dropped byte).
module nf_uart_loader
    import nf_uart_loader_pkg::*;
#(
    parameter int TIMEOUT_CYC = 8680
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] addr,
    output logic [31:0] wd,
    output logic        we,
    output logic        re,
    input  logic [31:0] rd,
    output logic        busy,
    output logic        err
);

    state_t      state, state_n;
    logic        cmd_w;
    logic [1:0]  bcnt;
    logic [31:0] rsp;
    logic [1:0]  left;
    logic        err_n;
    logic        in_field;
    logic        expire;

    assign in_field = (state == S_ADDR) || (state == S_DATA);

    // Clearing whenever outside ADDR/DATA also covers the clear-on-entry case.
    nf_uart_loader_tmr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmr (
        .clk    (clk),
        .resetn (resetn),
        .clear  (rx_valid || !in_field),
        .enable (in_field),
        .expire (expire)
    );

    assign we       = (state == S_WRITE);
    assign re       = (state == S_READ);
    assign busy     = (state != S_IDLE);
    assign tx_valid = (state == S_RESP);
    assign tx_data  = tx_valid ? rsp[7:0] : 8'h00;

    always_comb begin
        state_n = state;
        err_n   = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_W || rx_data == CMD_R) begin
                        state_n = S_ADDR;
                    end else begin
                        state_n = S_RESP;
                        err_n   = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                // A byte arriving on the expiry cycle wins over the timeout.
                if (rx_valid) begin
                    if (bcnt == 2'd3) state_n = cmd_w ? S_DATA : S_READ;
                end else if (expire) begin
                    state_n = S_IDLE;
                    err_n   = 1'b1;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    if (bcnt == 2'd3) state_n = S_WRITE;
                end else if (expire) begin
                    state_n = S_IDLE;
                    err_n   = 1'b1;
                end
            end
            S_WRITE: begin
                state_n = S_RESP;
                err_n   = rx_valid;
            end
            S_READ: begin
                state_n = S_CAPT;
                err_n   = rx_valid;
            end
            S_CAPT: begin
                state_n = S_RESP;
                err_n   = rx_valid;
            end
            S_RESP: begin
                if (tx_ready && left == 2'd0) state_n = S_IDLE;
                err_n = rx_valid;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state <= S_IDLE;
            err   <= 1'b0;
            cmd_w <= 1'b0;
            bcnt  <= 2'd0;
            addr  <= 32'h0;
            wd    <= 32'h0;
            rsp   <= 32'h0;
            left  <= 2'd0;
        end else begin
            state <= state_n;
            err   <= err_n;
            case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        cmd_w <= (rx_data == CMD_W);
                        bcnt  <= 2'd0;
                        rsp   <= {24'h0, RSP_ERR};
                        left  <= 2'd0;
                    end
                end
                S_ADDR: begin
                    if (rx_valid) begin
                        addr[{bcnt, 3'b000} +: 8] <= rx_data;
                        bcnt <= bcnt + 2'd1;
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        wd[{bcnt, 3'b000} +: 8] <= rx_data;
                        bcnt <= bcnt + 2'd1;
                    end
                end
                S_WRITE: begin
                    rsp  <= {24'h0, RSP_OK};
                    left <= 2'd0;
                end
                S_CAPT: begin
                    rsp  <= rd;
                    left <= 2'd3;
                end
                S_RESP: begin
                    if (tx_ready) begin
                        rsp  <= {8'h00, rsp[31:8]};
                        left <= left - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nf_uart_loader.sv
// tb/tb_nf_uart_loader.sv - self-checking bench for nf_uart_loader
module tb_nf_uart_loader;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        we;
    logic        re;
    logic [31:0] rd = 32'h0;
    logic        busy;
    logic        err;

    nf_uart_loader #(.TIMEOUT_CYC(TMO)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .addr     (addr),
        .wd       (wd),
        .we       (we),
        .re       (re),
        .rd       (rd),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    int we_cnt = 0;
    int re_cnt = 0;

    logic [7:0]  tx_q[$];
    logic [63:0] wr_q[$];
    logic [31:0] rd_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %h expected nothing", name, act);
    endtask

    // Scoreboard: every tx handshake and bus strobe must match a queued expectation.
    always @(negedge clk) begin
        if (!resetn) begin
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) fail_now("tx_unexpected", {24'h0, tx_data});
                else chk("tx_byte", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
            end
            if (we) begin
                logic [63:0] e;
                we_cnt++;
                if (wr_q.size() == 0) fail_now("we_unexpected", addr);
                else begin
                    e = wr_q.pop_front();
                    chk("we_addr", addr, e[63:32]);
                    chk("we_wd", wd, e[31:0]);
                end
            end
            if (re) begin
                re_cnt++;
                if (rd_q.size() == 0) fail_now("re_unexpected", addr);
                else chk("re_addr", addr, rd_q.pop_front());
            end
            if (err) err_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (busy && t < 2000) begin
            tick(1);
            t++;
        end
        chk({name, "_idle"}, {31'h0, busy}, 32'h0);
        tick(2);
    endtask

    task automatic run_frame(input string name, input logic [7:0] cmd, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] rv, input int exp_err);
        int e0;
        logic [31:0] wd0;
        e0  = err_cnt;
        wd0 = wd;
        if (cmd == 8'h57) begin
            tx_q.push_back(8'h4B);
            wr_q.push_back({a, d});
        end else if (cmd == 8'h52) begin
            rd = rv;
            rd_q.push_back(a);
            for (int i = 0; i < 4; i++) tx_q.push_back(rv[8*i +: 8]);
        end else begin
            tx_q.push_back(8'h3F);
        end
        send(cmd);
        if (cmd == 8'h57 || cmd == 8'h52)
            for (int i = 0; i < 4; i++) send(a[8*i +: 8]);
        if (cmd == 8'h57)
            for (int i = 0; i < 4; i++) send(d[8*i +: 8]);
        wait_idle(name);
        chk({name, "_err"}, 32'(err_cnt - e0), 32'(exp_err));
        chk({name, "_txq"}, 32'(tx_q.size()), 32'h0);
        if (cmd == 8'h52) chk({name, "_wd_kept"}, wd, wd0);
        if (cmd == 8'h57 || cmd == 8'h52) chk({name, "_addr_hold"}, addr, a);
    endtask

    typedef struct {
        string       name;
        logic [7:0]  cmd;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rv;
        int          exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int we0, re0, e0, t;
        logic [7:0] held;
        logic stable;

        vecs[0] = '{"wr_basic", 8'h57, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0};
        vecs[1] = '{"rd_basic", 8'h52, 32'h0000_0020, 32'h0, 32'h1234_5678, 0};
        vecs[2] = '{"bad_41",   8'h41, 32'h0, 32'h0, 32'h0, 1};
        vecs[3] = '{"wr_high",  8'h57, 32'hFFFF_FFFC, 32'h0000_0001, 32'h0, 0};
        vecs[4] = '{"rd_high",  8'h52, 32'h8000_0000, 32'h0, 32'hA5A5_5A5A, 0};
        vecs[5] = '{"bad_00",   8'h00, 32'h0, 32'h0, 32'h0, 1};

        tick(3);
        chk("reset_outputs", {tx_data, 6'h0, tx_valid, we, re, busy, err, 11'h0},
            32'h0);
        chk("reset_addr", addr, 32'h0);
        chk("reset_wd", wd, 32'h0);
        resetn = 1'b0;
        tick(2);

        for (int i = 0; i < 6; i++)
            run_frame(vecs[i].name, vecs[i].cmd, vecs[i].a, vecs[i].d, vecs[i].rv, vecs[i].exp_err);

        // Timeout after two address bytes: no strobe, no response, then recovery.
        we0 = we_cnt;
        e0  = err_cnt;
        send(8'h57);
        send(8'h10);
        send(8'h00);
        tick(TMO + 5);
        chk("tmo_busy", {31'h0, busy}, 32'h0);
        chk("tmo_err", 32'(err_cnt - e0), 32'h1);
        chk("tmo_no_we", 32'(we_cnt - we0), 32'h0);
        run_frame("after_tmo", 8'h57, 32'h0000_0044, 32'h0BAD_F00D, 32'h0, 0);

        // Each byte lands on the expiry cycle itself and must be accepted.
        e0 = err_cnt;
        tx_q.push_back(8'h4B);
        wr_q.push_back({32'h7654_3210, 32'hCAFE_0123});
        send(8'h57);
        for (int i = 0; i < 4; i++) begin
            tick(TMO - 1);
            send(8'(32'h7654_3210 >> (8*i)));
        end
        for (int i = 0; i < 4; i++) begin
            tick(TMO - 1);
            send(8'(32'hCAFE_0123 >> (8*i)));
        end
        wait_idle("edge_tmo");
        chk("edge_tmo_err", 32'(err_cnt - e0), 32'h0);
        chk("edge_tmo_txq", 32'(tx_q.size()), 32'h0);

        // Backpressure during a read response with a byte dropped mid-stall.
        tx_ready = 1'b0;
        e0 = err_cnt;
        rd = 32'h1234_5678;
        rd_q.push_back(32'h0000_0030);
        for (int i = 0; i < 4; i++) tx_q.push_back(rd[8*i +: 8]);
        send(8'h52);
        for (int i = 0; i < 4; i++) send(8'(32'h30 >> (8*i)));
        t = 0;
        while (!tx_valid && t < 20) begin
            tick(1);
            t++;
        end
        chk("bp_tx_valid", {31'h0, tx_valid}, 32'h1);
        held = tx_data;
        chk("bp_first", {24'h0, held}, 32'h78);
        stable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i == 50) send(8'hAA);
            else tick(1);
            if (tx_data !== held || tx_valid !== 1'b1) stable = 1'b0;
        end
        chk("bp_stable", {31'h0, stable}, 32'h1);
        chk("bp_err", 32'(err_cnt - e0), 32'h1);
        tx_ready = 1'b1;
        wait_idle("bp");
        chk("bp_txq", 32'(tx_q.size()), 32'h0);

        // Asynchronous reset after data byte 2 abandons the write.
        we0 = we_cnt;
        send(8'h57);
        for (int i = 0; i < 4; i++) send(8'h11);
        send(8'hEF);
        send(8'hBE);
        #1 resetn = 1'b1;
        #1;
        chk("rst_outputs", {tx_data, 6'h0, tx_valid, we, re, busy, err, 11'h0}, 32'h0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_wd", wd, 32'h0);
        tick(3);
        resetn = 1'b0;
        tick(20);
        chk("rst_no_we", 32'(we_cnt - we0), 32'h0);
        chk("rst_idle", {31'h0, busy}, 32'h0);
        chk("final_wrq", 32'(wr_q.size()), 32'h0);
        chk("final_rdq", 32'(rd_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nf_uart_loader.md
NF_UART_LOADER -- requirements
Module: nf_uart_loader

Interface
REQ-001 Parameter TIMEOUT_CYC, 8680, idle clocks allowed between bytes of one frame before it is aborted.
REQ-002 clk  input  1  system clock; all logic rising-edge.
REQ-003 resetn  input  1  reset, asynchronous, active-high.
REQ-004 rx_data  input  8  byte from UART receiver.
REQ-005 rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-006 tx_data  output  8  response byte to UART transmitter.
REQ-007 tx_valid  output  1  tx_data valid; held until accepted.
REQ-008 tx_ready  input  1  transmitter can accept a byte.
REQ-009 addr  output  32  bus address.
REQ-010 wd  output  32  bus write data.
REQ-011 we  output  1  bus write strobe, one cycle.
REQ-012 re  output  1  bus read strobe, one cycle.
REQ-013 rd  input  32  bus read data, valid the cycle after re.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 err  output  1  one-cycle pulse on protocol error, timeout or dropped byte.

Function
REQ-016 Frame "write" SHALL be: 0x57, 4 address bytes, 4 data bytes; all multi-byte fields little-endian.
REQ-017 Frame "read" SHALL be: 0x52, 4 address bytes.
REQ-018 States SHALL be IDLE, ADDR, DATA, WRITE, READ, CAPT, RESP.
REQ-019 IDLE: rx_valid with 0x57 or 0x52 -> ADDR, command latched, byte counter cleared; any other byte -> RESP with response 0x3F and err pulse.
REQ-020 ADDR: each rx_valid shifts rx_data into addr byte [counter]; after 4th byte -> DATA (write) or READ (read).
REQ-021 DATA: same for wd; after 4th byte -> WRITE.
REQ-022 WRITE: we=1 exactly one cycle with stable addr/wd; then RESP with response 0x4B.
REQ-023 READ: re=1 exactly one cycle; next state CAPT.
REQ-024 CAPT: rd latched into 32-bit response shift register; -> RESP with 4 bytes to send, LSB first.
REQ-025 RESP: tx_valid=1 with current byte; on tx_valid&&tx_ready advance; after last accepted byte -> IDLE the next cycle.
REQ-026 tx_data/tx_valid SHALL not change while tx_valid=1 and tx_ready=0.
REQ-027 rx_valid in WRITE, READ, CAPT or RESP SHALL be dropped and pulse err; state unaffected.
REQ-028 Timeout counter SHALL clear on every rx_valid and on entry to ADDR; counts only in ADDR/DATA.
REQ-029 Counter reaching TIMEOUT_CYC-1 in ADDR/DATA -> IDLE, err pulse, no bus strobe, no response.
REQ-030 rx_valid in the same cycle as timeout expiry SHALL win: byte accepted, counter cleared.
REQ-031 Counter width SHALL be $clog2(TIMEOUT_CYC)+1; no wrap beyond TIMEOUT_CYC.
REQ-032 addr/wd SHALL hold last values in IDLE; reading frame does not alter wd.
REQ-033 Byte counter 2 bits, wraps 3->0 on the 4th byte of a field.

Reset
REQ-034 resetn=1 SHALL force, asynchronously: state IDLE, addr=0, wd=0, we=0, re=0, tx_data=0, tx_valid=0, busy=0, err=0, counters 0.
REQ-035 Reset mid-frame or mid-response SHALL abandon it; no bus strobe or tx byte after release until a new frame.

Structure
REQ-036 Package nf_uart_loader_pkg SHALL hold state enum and constants CMD_W=8'h57, CMD_R=8'h52, RSP_OK=8'h4B, RSP_ERR=8'h3F.
REQ-037 Timeout counter SHALL be sub-module nf_uart_loader_tmr (clear, enable, expire out).

Verification
REQ-038 Bytes 57 10 00 00 00 EF BE AD DE, tx_ready=1 -> one we pulse, addr=0x00000010, wd=0xDEADBEEF; tx byte 0x4B; busy low after.
REQ-039 Bytes 52 20 00 00 00, rd=0x12345678 -> one re pulse, addr=0x00000020; tx bytes 78 56 34 12 in order.
REQ-040 Byte 0x41 in IDLE -> err pulse, tx byte 0x3F, no we/re.
REQ-041 57 + two address bytes then TIMEOUT_CYC idle clocks -> err pulse, IDLE, no we, no tx; following valid frame works.
REQ-042 Read frame with tx_ready=0 for 100 cycles during RESP, extra rx_valid injected -> tx_data stable, err pulse, all 4 bytes sent after tx_ready=1.
REQ-043 resetn asserted after data byte 2 of a write frame -> all outputs 0 immediately; no we after release.
